onehot_pulse_decoder: RTL and testbench



---
 rtl/onehot_pulse_decoder.sv | 136 +++++++++++++
 tb/tb_onehot_pulse_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder
// Sequential 3-to-8 binary-to-one-hot decoder. A code accepted over a
// valid/ready handshake drives bit[code] of o_data for HOLD cycles, followed
// by GAP all-zero cycles. A one-entry pending buffer lets the producer queue
// the next code while a pulse (or its trailing gap) is still in flight.
module onehot_pulse_decoder #(
  parameter int HOLD = 4,  // cycles each pulse stays asserted, 1..255
  parameter int GAP  = 1   // forced zero cycles between pulses, 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_code,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Counter reload values: the counter counts down to zero, so a phase of
  // N cycles is loaded with N-1. The gap reload is guarded so GAP=0 still
  // elaborates to a legal constant even though that branch is never taken.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit         HAS_GAP   = (GAP > 0);

  state_t     r_state;
  logic [7:0] r_data;
  logic [7:0] r_cnt;
  logic       r_pendValid;
  logic [2:0] r_pendCode;

  logic       w_accept;
  logic       w_nextAvail;
  logic [2:0] w_nextCode;
  logic       w_cntZero;

  // Decode a binary index into its one-hot line.
  function automatic logic [7:0] oneHot(input logic [2:0] c);
    oneHot = 8'b0000_0001 << c;
  endfunction

  // Ready only drops while the pending slot is occupied (and during reset).
  assign o_ready     = !rst && !r_pendValid;
  assign w_accept    = i_valid && o_ready;

  // The next code to load: the pending entry always wins; otherwise a code
  // accepted on this very edge bypasses the buffer.
  assign w_nextAvail = r_pendValid || w_accept;
  assign w_nextCode  = r_pendValid ? r_pendCode : i_code;

  assign w_cntZero   = (r_cnt == 8'd0);

  assign o_data      = r_data;
  assign o_busy      = (r_state != ST_IDLE);

  // Single state machine: phase sequencing, pulse/gap timing, pending buffer
  // and the registered one-hot output all update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_data      <= 8'd0;
      r_cnt       <= 8'd0;
      r_pendValid <= 1'b0;
      r_pendCode  <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_data <= 8'd0;
          if (w_accept) begin
            r_state <= ST_ACTIVE;
            r_data  <= oneHot(i_code);
            r_cnt   <= HOLD_LOAD;
          end
        end

        ST_ACTIVE: begin
          if (!w_cntZero) begin
            r_cnt <= r_cnt - 8'd1;
            if (w_accept) begin
              r_pendValid <= 1'b1;
              r_pendCode  <= i_code;
            end
          end else if (HAS_GAP) begin
            r_state <= ST_GAP;
            r_data  <= 8'd0;
            r_cnt   <= GAP_LOAD;
            if (w_accept) begin
              r_pendValid <= 1'b1;
              r_pendCode  <= i_code;
            end
          end else if (w_nextAvail) begin
            r_state     <= ST_ACTIVE;
            r_data      <= oneHot(w_nextCode);
            r_cnt       <= HOLD_LOAD;
            r_pendValid <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_data  <= 8'd0;
          end
        end

        ST_GAP: begin
          r_data <= 8'd0;
          if (!w_cntZero) begin
            r_cnt <= r_cnt - 8'd1;
            if (w_accept) begin
              r_pendValid <= 1'b1;
              r_pendCode  <= i_code;
            end
          end else if (w_nextAvail) begin
            r_state     <= ST_ACTIVE;
            r_data      <= oneHot(w_nextCode);
            r_cnt       <= HOLD_LOAD;
            r_pendValid <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_data      <= 8'd0;
          r_cnt       <= 8'd0;
          r_pendValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder
// Two decoder instances: A with HOLD=4/GAP=1, B with HOLD=1/GAP=0.
// Directed table vectors, hand sequences and a randomized run against a
// slot-based reference model.
module tb_onehot_pulse_decoder;

  localparam int A_HOLD = 4;
  localparam int A_GAP  = 1;
  localparam int B_HOLD = 1;
  localparam int B_GAP  = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] aCode = 3'd0;
  logic       aValid = 1'b0;
  logic       aReady;
  logic [7:0] aData;
  logic       aBusy;
  logic [2:0] bCode = 3'd0;
  logic       bValid = 1'b0;
  logic       bReady;
  logic [7:0] bData;
  logic       bBusy;

  int totalCount = 0;
  int badCount   = 0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  onehot_pulse_decoder #(.HOLD(A_HOLD), .GAP(A_GAP)) dutA (
    .clk(clk), .rst(rst), .i_code(aCode), .i_valid(aValid),
    .o_ready(aReady), .o_data(aData), .o_busy(aBusy)
  );

  onehot_pulse_decoder #(.HOLD(B_HOLD), .GAP(B_GAP)) dutB (
    .clk(clk), .rst(rst), .i_code(bCode), .i_valid(bValid),
    .o_ready(bReady), .o_data(bData), .o_busy(bBusy)
  );

  // Reference model: each pulse occupies a slot of HOLD+GAP cycles; the
  // line is lit for the first HOLD positions. A one-deep queue holds the
  // code waiting for the next slot.
  int         mHold[2] = '{A_HOLD, B_HOLD};
  int         mGap[2]  = '{A_GAP, B_GAP};
  bit         mBusy[2];
  int         mPos[2];
  logic [2:0] mCode[2];
  bit         mPendValid[2];
  logic [2:0] mPendCode[2];

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      mBusy[k] = 0; mPos[k] = 0; mCode[k] = 3'd0;
      mPendValid[k] = 0; mPendCode[k] = 3'd0;
    end
  endfunction

  function automatic void modelStart(int k, logic [2:0] c);
    mBusy[k] = 1; mPos[k] = 0; mCode[k] = c;
  endfunction

  function automatic void modelEdge(int k, logic v, logic [2:0] c);
    bit acc;
    acc = v && !mPendValid[k];
    if (mBusy[k] && mPos[k] < mHold[k] + mGap[k] - 1) begin
      mPos[k]++;
      if (acc) begin mPendValid[k] = 1; mPendCode[k] = c; end
    end else if (mPendValid[k]) begin
      modelStart(k, mPendCode[k]);
      mPendValid[k] = 0;
    end else if (acc) begin
      modelStart(k, c);
    end else begin
      mBusy[k] = 0;
    end
  endfunction

  function automatic logic [7:0] modelData(int k);
    if (mBusy[k] && mPos[k] < mHold[k]) return 8'd1 << mCode[k];
    return 8'd0;
  endfunction

  task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
    totalCount++;
    if (act !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(string name, logic act, logic exp);
    totalCount++;
    if (act !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic [2:0] c, logic v);
    aCode = c;
    aValid = v;
  endtask

  // Advance one clock; the model sees the same pre-edge inputs as the DUTs.
  task automatic tick();
    @(posedge clk);
    if (rst) modelReset();
    else begin
      modelEdge(0, aValid, aCode);
      modelEdge(1, bValid, bCode);
    end
    #1;
  endtask

  task automatic checkModel();
    checkOutput("A_data_model", aData, modelData(0));
    checkBit("A_ready_model", aReady, !mPendValid[0]);
    checkBit("A_busy_model", aBusy, mBusy[0]);
    checkOutput("B_data_model", bData, modelData(1));
    checkBit("B_ready_model", bReady, !mPendValid[1]);
    checkBit("B_busy_model", bBusy, mBusy[1]);
  endtask

  task automatic waitIdle(int budget);
    int n = 0;
    while (aBusy && n < budget) begin
      tick();
      checkOutput("A_onehot", 8'($countones(aData) <= 1), 8'd1);
      n++;
    end
    checkBit("A_idle_timeout", aBusy, 1'b0);
  endtask

  typedef struct {
    logic [2:0] code;
    logic       valid;
    logic [7:0] expData;
    logic       expReady;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(logic [2:0] c, logic v, logic [7:0] d, logic r, logic b);
    vec_t t;
    t.code = c; t.valid = v; t.expData = d; t.expReady = r; t.expBusy = b;
    vecs.push_back(t);
  endfunction

  initial begin
    // Single pulse of code 5: four cycles lit, one gap cycle, then idle.
    addVec(3'd5, 1'b1, 8'h20, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h20, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h20, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h20, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h00, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    // Code 2, then 6 queued in pending, then 1 stalled until ready returns.
    addVec(3'd2, 1'b1, 8'h04, 1'b1, 1'b1);
    addVec(3'd6, 1'b1, 8'h04, 1'b0, 1'b1);
    addVec(3'd1, 1'b1, 8'h04, 1'b0, 1'b1);
    addVec(3'd1, 1'b1, 8'h04, 1'b0, 1'b1);
    addVec(3'd1, 1'b1, 8'h00, 1'b0, 1'b1);
    addVec(3'd1, 1'b1, 8'h40, 1'b1, 1'b1);
    addVec(3'd1, 1'b1, 8'h40, 1'b0, 1'b1);
    addVec(3'd0, 1'b0, 8'h40, 1'b0, 1'b1);
    addVec(3'd0, 1'b0, 8'h40, 1'b0, 1'b1);
    addVec(3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    addVec(3'd0, 1'b0, 8'h02, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h02, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h02, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h02, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h00, 1'b1, 1'b1);
    addVec(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

    modelReset();

    // Reset state, observed while rst is held.
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_data", aData, 8'h00);
    checkBit("rst_ready", aReady, 1'b0);
    checkBit("rst_busy", aBusy, 1'b0);
    checkOutput("rst_dataB", bData, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkBit("post_rst_ready", aReady, 1'b1);

    // Quiet inputs: nothing happens.
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("quiet_data", aData, 8'h00);
      checkBit("quiet_busy", aBusy, 1'b0);
      checkBit("quiet_ready", aReady, 1'b1);
    end

    // Directed vector table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].code, vecs[i].valid);
      tick();
      checkOutput($sformatf("vec%0d_data", i), aData, vecs[i].expData);
      checkBit($sformatf("vec%0d_ready", i), aReady, vecs[i].expReady);
      checkBit($sformatf("vec%0d_busy", i), aBusy, vecs[i].expBusy);
    end
    applyStimulus(3'd0, 1'b0);

    // Sweep every code, one pulse at a time.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(3'(c), 1'b1);
      tick();
      checkOutput($sformatf("sweep%0d_data", c), aData, 8'(1 << c));
      applyStimulus(3'd0, 1'b0);
      waitIdle(20);
    end

    // Instance B: HOLD=1, GAP=0 gives back-to-back single-cycle pulses.
    bValid = 1'b1; bCode = 3'd3;
    tick();
    checkOutput("b2b_3", bData, 8'h08);
    checkBit("b2b_ready3", bReady, 1'b1);
    bCode = 3'd4;
    tick();
    checkOutput("b2b_4", bData, 8'h10);
    checkBit("b2b_ready4", bReady, 1'b1);
    bCode = 3'd7;
    tick();
    checkOutput("b2b_7", bData, 8'h80);
    checkBit("b2b_ready7", bReady, 1'b1);
    bValid = 1'b0;
    tick();
    checkOutput("b2b_end", bData, 8'h00);
    checkBit("b2b_busy_end", bBusy, 1'b0);

    // Asynchronous reset mid-pulse with a code waiting in pending.
    applyStimulus(3'd3, 1'b1);
    tick();
    applyStimulus(3'd6, 1'b1);
    tick();
    checkBit("pend_ready", aReady, 1'b0);
    applyStimulus(3'd0, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_data", aData, 8'h00);
    checkBit("async_busy", aBusy, 1'b0);
    checkBit("async_ready", aReady, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkBit("release_ready", aReady, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("no_stale_data", aData, 8'h00);
      checkBit("no_stale_busy", aBusy, 1'b0);
    end

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4));
      bCode = 3'($urandom_range(0, 7));
      bValid = ($urandom_range(0, 9) < 5);
      tick();
      checkModel();
    end
    applyStimulus(3'd0, 1'b0);
    bValid = 1'b0;
    waitIdle(40);
    tick();
    checkModel();

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
